// File: rtl/avl_ram_pkg.sv
// Shared definitions for the Avalon-MM burst RAM: default depth, response
// codes, the controller state encoding and a burst-length helper.
package configure;

  // Default number of 32-bit words in the RAM.
  localparam int AVL_RAM_DEPTH = 4096;

  // Response codes driven with readdatavalid / writeresponsevalid.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // A burstcount of zero means a single beat.
  function automatic logic [2:0] beat_count(input logic [2:0] burstcount);
    return (burstcount == 3'd0) ? 3'd1 : burstcount;
  endfunction

endpackage

// File: rtl/avl_ram_if.sv
// Avalon-MM slave bus of the burst RAM, grouped so the controller and its
// bench share one bundle. Clock and reset stay outside as plain ports.
interface avl_ram_if;

  logic [31:0] s_avl_address;
  logic [3:0]  s_avl_byteenable;
  logic        s_avl_lock;
  logic        s_avl_read;
  logic [31:0] s_avl_writedata;
  logic        s_avl_write;
  logic [2:0]  s_avl_burstcount;
  logic [31:0] s_avl_readdata;
  logic [1:0]  s_avl_response;
  logic        s_avl_waitrequest;
  logic        s_avl_readdatavalid;
  logic        s_avl_writeresponsevalid;

  // Bus master side (the bench or an interconnect).
  modport master (
    output s_avl_address,
    output s_avl_byteenable,
    output s_avl_lock,
    output s_avl_read,
    output s_avl_writedata,
    output s_avl_write,
    output s_avl_burstcount,
    input  s_avl_readdata,
    input  s_avl_response,
    input  s_avl_waitrequest,
    input  s_avl_readdatavalid,
    input  s_avl_writeresponsevalid
  );

  // RAM side.
  modport slave (
    input  s_avl_address,
    input  s_avl_byteenable,
    input  s_avl_lock,
    input  s_avl_read,
    input  s_avl_writedata,
    input  s_avl_write,
    input  s_avl_burstcount,
    output s_avl_readdata,
    output s_avl_response,
    output s_avl_waitrequest,
    output s_avl_readdatavalid,
    output s_avl_writeresponsevalid
  );

endinterface

// File: rtl/avl_ram_array.sv
// Single-port synchronous word array with per-byte write strobes and a
// registered read port (one cycle latency). Contents are never reset.
module avl_ram_array
  import configure::*;
#(
  parameter int depth = AVL_RAM_DEPTH,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clock,
  input  logic          enable,
  input  logic [3:0]    wstrb,
  input  logic [aw-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [depth];

  // Enabled access: update strobed lanes and capture the addressed word.
  always_ff @(posedge clock) begin
    if (enable) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wstrb[lane]) begin
          mem[index][8*lane +: 8] <= wdata[8*lane +: 8];
        end
      end
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/avl_ram.sv
// Avalon-MM burst RAM controller. Accepts one read or write burst at a time,
// streams read beats from the word array, collects write beats, and reports
// out-of-range bursts with SLVERR while suppressing their effect.
//
// Handshake: a command (read or write, with address and burstcount) is taken
// on a rising edge where waitrequest is 0 in IDLE; write wins if both are
// high. Further write beats are taken on every edge in WRITE where write is 1.
// Each cycle with readdatavalid = 1 carries exactly one read beat; a cycle
// with writeresponsevalid = 1 closes exactly one write burst. Neither valid
// can be back-pressured by the master.
module avl_ram
  import configure::*;
#(
  parameter int          avl_ram_depth = AVL_RAM_DEPTH,
  parameter logic [31:0] avl_ram_base  = 32'h0000_0000
) (
  input  logic   clock,
  input  logic   reset,
  avl_ram_if.slave avl,
  output state_e dbg_state_o
);

  localparam int AW = $clog2(avl_ram_depth);
  typedef logic [AW-1:0] idx_t;

  state_e      state_q, state_d;
  logic        ready_q;
  idx_t        idx_q, idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        mem_en;
  logic [3:0]  mem_wstrb;
  idx_t        mem_idx;
  logic [31:0] mem_rdata;

  logic [31:0] offset;
  logic [31:0] word_full;
  idx_t        start_idx;
  logic        start_err;
  logic [2:0]  beats;
  logic        unused_bits;

  // Command decode: byte offset from the base, full word index and range check.
  assign offset    = avl.s_avl_address - avl_ram_base;
  assign word_full = {2'b00, offset[31:2]};
  assign start_idx = offset[AW+1:2];
  assign start_err = (word_full >= 32'(avl_ram_depth));
  assign beats     = beat_count(avl.s_avl_burstcount);

  // Lock and the byte offset inside a word carry no meaning here.
  assign unused_bits = ^{avl.s_avl_lock, offset[1:0]};

  // State and burst-tracking registers; ready_q holds waitrequest high
  // until the first edge after reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state, burst bookkeeping and array access control. idx_q always
  // points at the next word to touch; cnt_q counts beats still to issue
  // (READ) or still to accept (WRITE).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mem_en    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_idx   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && avl.s_avl_write) begin
          err_d     = start_err;
          mem_en    = 1'b1;
          mem_idx   = start_idx;
          mem_wstrb = start_err ? 4'b0000 : avl.s_avl_byteenable;
          idx_d     = start_idx + idx_t'(1);
          cnt_d     = beats - 3'd1;
          state_d   = (beats == 3'd1) ? ST_RESP : ST_WRITE;
        end else if (ready_q && avl.s_avl_read) begin
          err_d   = start_err;
          mem_en  = 1'b1;
          mem_idx = start_idx;
          idx_d   = start_idx + idx_t'(1);
          cnt_d   = beats - 3'd1;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        // The beat on the bus now was fetched last cycle; prefetch the next.
        if (cnt_q != 3'd0) begin
          mem_en = 1'b1;
          idx_d  = idx_q + idx_t'(1);
          cnt_d  = cnt_q - 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (avl.s_avl_write) begin
          mem_en    = 1'b1;
          mem_wstrb = err_q ? 4'b0000 : avl.s_avl_byteenable;
          idx_d     = idx_q + idx_t'(1);
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  avl_ram_array #(
    .depth (avl_ram_depth),
    .aw    (AW)
  ) u_array (
    .clock  (clock),
    .enable (mem_en),
    .wstrb  (mem_wstrb),
    .index  (mem_idx),
    .wdata  (avl.s_avl_writedata),
    .rdata  (mem_rdata)
  );

  // Bus outputs are pure decodes of the registered state.
  assign avl.s_avl_waitrequest        = !ready_q || (state_q == ST_READ) || (state_q == ST_RESP);
  assign avl.s_avl_readdatavalid      = (state_q == ST_READ);
  assign avl.s_avl_writeresponsevalid = (state_q == ST_RESP);
  assign avl.s_avl_readdata           = ((state_q == ST_READ) && !err_q) ? mem_rdata : 32'h0;
  assign avl.s_avl_response           = (((state_q == ST_READ) || (state_q == ST_RESP)) && err_q)
                                        ? RESP_SLVERR : RESP_OKAY;
  assign dbg_state_o                  = state_q;

endmodule

// File: tb/tb_avl_ram.sv
// Bench for avl_ram: driver tasks issue bursts and push expected beats and
// write responses (with the cycle they must appear in) into queues; a monitor
// on the falling edge pops and compares whatever the RAM presents.
module tb_avl_ram;
  import configure::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  state_e dbg_state;
  int     cyc = 0;

  avl_ram_if avl();

  avl_ram #(
    .avl_ram_depth (DEPTH),
    .avl_ram_base  (BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .avl         (avl),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_mem [DEPTH];
  logic [65:0] exp_q [$];   // {cycle, response, readdata}
  logic [33:0] wr_q  [$];   // {cycle, response}
  logic [31:0] wd [8];
  logic [3:0]  wb [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr - BASE) >> 2;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [65:0] e;
    logic [33:0] r;
    if (avl.s_avl_readdatavalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got beat %0h want none (cycle %0d)", avl.s_avl_readdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(e[65:34]));
        chk("rd_data", 64'(avl.s_avl_readdata), 64'(e[31:0]));
        chk("rd_resp", 64'(avl.s_avl_response), 64'(e[33:32]));
        chk("rd_waitreq", 64'(avl.s_avl_waitrequest), 64'd1);
      end
    end else begin
      chk("rdata_idle", 64'(avl.s_avl_readdata), 64'd0);
    end
    if (avl.s_avl_writeresponsevalid) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got response %0h want none (cycle %0d)", avl.s_avl_response, cyc);
      end else begin
        r = wr_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(r[33:2]));
        chk("wr_resp", 64'(avl.s_avl_response), 64'(r[1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!avl.s_avl_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got waitrequest=1 want 0 within 200 cycles");
    end
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [2:0] bc,
                          input int stall_at, input int stall_len, input logic with_read);
    int          n;
    int          t;
    int          stalls;
    bit          ok;
    logic        err;
    logic [31:0] w;
    logic [31:0] mask;
    int          idx;
    n      = (bc == 3'd0) ? 1 : int'(bc);
    w      = word_of(addr);
    err    = (w >= DEPTH);
    stalls = (stall_at >= 1 && stall_at < n) ? stall_len : 0;
    @(posedge clock);
    #1;
    avl.s_avl_address    = addr;
    avl.s_avl_burstcount = bc;
    avl.s_avl_write      = 1'b1;
    avl.s_avl_read       = with_read;
    avl.s_avl_writedata  = wd[0];
    avl.s_avl_byteenable = wb[0];
    avl.s_avl_lock       = 1'($urandom_range(0, 1));
    wait_accept(ok);
    t = cyc;
    wr_q.push_back({32'(t + n + stalls), err ? RESP_SLVERR : RESP_OKAY});
    if (!err) begin
      for (int b = 0; b < n; b++) begin
        idx  = (int'(w) + b) % DEPTH;
        mask = 32'h0;
        for (int l = 0; l < 4; l++) if (wb[b][l]) mask[8*l +: 8] = 8'hFF;
        model_mem[idx] = (model_mem[idx] & ~mask) | (wd[b] & mask);
      end
    end
    @(posedge clock);
    #1;
    avl.s_avl_read = 1'b0;
    for (int b = 1; b < n; b++) begin
      if (b == stall_at) begin
        avl.s_avl_write = 1'b0;
        avl.s_avl_read  = 1'($urandom_range(0, 1));
        repeat (stall_len) @(posedge clock);
        #1;
      end
      avl.s_avl_write      = 1'b1;
      avl.s_avl_read       = 1'($urandom_range(0, 1));
      avl.s_avl_writedata  = wd[b];
      avl.s_avl_byteenable = wb[b];
      avl.s_avl_address    = $urandom;
      @(posedge clock);
      #1;
    end
    avl.s_avl_write = 1'b0;
    avl.s_avl_read  = 1'b0;
  endtask

  // push_n < 0 expects every beat; otherwise only the first push_n beats.
  task automatic rd_burst(input logic [31:0] addr, input logic [2:0] bc, input int push_n);
    int          n;
    int          t;
    int          m;
    bit          ok;
    logic        err;
    logic [31:0] w;
    n   = (bc == 3'd0) ? 1 : int'(bc);
    m   = (push_n < 0) ? n : push_n;
    w   = word_of(addr);
    err = (w >= DEPTH);
    @(posedge clock);
    #1;
    avl.s_avl_address    = addr;
    avl.s_avl_burstcount = bc;
    avl.s_avl_read       = 1'b1;
    avl.s_avl_write      = 1'b0;
    avl.s_avl_writedata  = $urandom;
    avl.s_avl_byteenable = 4'($urandom_range(0, 15));
    avl.s_avl_lock       = 1'($urandom_range(0, 1));
    wait_accept(ok);
    t = cyc;
    for (int b = 0; b < m; b++) begin
      exp_q.push_back({32'(t + 1 + b), err ? RESP_SLVERR : RESP_OKAY,
                       err ? 32'h0 : model_mem[(int'(w) + b) % DEPTH]});
    end
    @(posedge clock);
    #1;
    avl.s_avl_read = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge clock);
    end
    chk("drain", 64'(exp_q.size() + wr_q.size()), 64'd0);
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < 8; b++) begin
      wd[b] = $urandom;
      wb[b] = 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int          r;
    avl.s_avl_address    = 32'h0;
    avl.s_avl_byteenable = 4'h0;
    avl.s_avl_lock       = 1'b0;
    avl.s_avl_read       = 1'b0;
    avl.s_avl_writedata  = 32'h0;
    avl.s_avl_write      = 1'b0;
    avl.s_avl_burstcount = 3'd0;

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst_waitreq", 64'(avl.s_avl_waitrequest), 64'd1);
    chk("rst_rvalid", 64'(avl.s_avl_readdatavalid), 64'd0);
    chk("rst_wrvalid", 64'(avl.s_avl_writeresponsevalid), 64'd0);
    chk("rst_rdata", 64'(avl.s_avl_readdata), 64'd0);
    chk("rst_resp", 64'(avl.s_avl_response), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rel_waitreq_hold", 64'(avl.s_avl_waitrequest), 64'd1);
    @(negedge clock);
    chk("rel_waitreq_drop", 64'(avl.s_avl_waitrequest), 64'd0);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) begin
      wd[0] = $urandom;
      wb[0] = 4'hF;
      wr_burst(BASE + 32'(4 * w), 3'd1, 0, 0, 1'b0);
    end
    wait_drain();

    // Single write then single read.
    wd[0] = 32'hDEADBEEF;
    wb[0] = 4'hF;
    wr_burst(BASE + 32'h10, 3'd1, 0, 0, 1'b0);
    rd_burst(BASE + 32'h10, 3'd1, -1);
    wait_drain();

    // Four-beat write with a two-cycle stall, then four-beat read.
    for (int b = 0; b < 4; b++) begin
      wd[b] = 32'(b + 1);
      wb[b] = 4'hF;
    end
    wr_burst(BASE + 32'h20, 3'd4, 1, 2, 1'b0);
    rd_burst(BASE + 32'h20, 3'd4, -1);
    wait_drain();

    // Byte-lane merge.
    wd[0] = 32'hAABBCCDD;
    wb[0] = 4'hF;
    wr_burst(BASE + 32'h40, 3'd1, 0, 0, 1'b0);
    wd[0] = 32'h11223344;
    wb[0] = 4'b0101;
    wr_burst(BASE + 32'h40, 3'd1, 0, 0, 1'b0);
    rd_burst(BASE + 32'h40, 3'd1, -1);
    wait_drain();

    // Wrap from the last word, then an out-of-range read.
    rd_burst(BASE + 32'(4 * (DEPTH - 1)), 3'd2, -1);
    rd_burst(BASE + 32'(4 * DEPTH), 3'd1, -1);
    wait_drain();

    // Read and write together with burstcount 0: only the write happens.
    wd[0] = 32'hCAFE0001;
    wb[0] = 4'hF;
    wr_burst(BASE + 32'h30, 3'd0, 0, 0, 1'b1);
    rd_burst(BASE + 32'h30, 3'd1, -1);
    wait_drain();

    // Randomized bursts, including out-of-range ones on both sides of the window.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'(4 * $urandom_range(DEPTH, DEPTH + 20));
      else             a = BASE - 32'(4 * $urandom_range(1, 8));
      fill_random(8);
      if ($urandom_range(0, 1) == 1)
        wr_burst(a, 3'($urandom_range(0, 7)), $urandom_range(0, 6), $urandom_range(1, 3),
                 1'($urandom_range(0, 1)));
      else
        rd_burst(a, 3'($urandom_range(0, 7)), -1);
    end
    wait_drain();

    // Reset during beat 2 of a four-beat read.
    rd_burst(BASE + 32'h20, 3'd4, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_rvalid", 64'(avl.s_avl_readdatavalid), 64'd0);
      chk("abort_waitreq", 64'(avl.s_avl_waitrequest), 64'd1);
      chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_rel_hold", 64'(avl.s_avl_waitrequest), 64'd1);
    @(negedge clock);
    chk("abort_rel_drop", 64'(avl.s_avl_waitrequest), 64'd0);
    chk("abort_idle", 64'(dbg_state), 64'(ST_IDLE));
    wait_drain();
    rd_burst(BASE + 32'h20, 3'd4, -1);
    rd_burst(BASE + 32'h40, 3'd1, -1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
